// File: rtl/trs_in_responder.sv
// trs_in_responder: answers Z80 IN cycles to the LE18 data port.
// Holds the Z80 in WAIT until the display block's read pipeline strobes
// le18_dout_rdy, then latches that byte and drives it until the IN ends.
// Optional feature macro: TRS_IN_TIMEOUT_EN (forced release from WAIT_DATA
// after TIMEOUT_CYCLES cycles, returning 8'hFF and setting timeout_flag).
module trs_in_responder #(
   parameter logic [7:0] PORT           = 8'hEC,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] TRS_A,
   input  logic       TRS_IN,
   input  logic [7:0] le18_dout,
   input  logic       le18_dout_rdy,
   output logic [7:0] TRS_DOUT,
   output logic       TRS_DOUT_EN,
   output logic       TRS_WAIT,
   output logic       timeout_flag
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      DRIVE     = 2'd2,
      HOLD      = 2'd3
   } state_t;

   state_t state, state_next;

   logic qual;
   logic qual_prev;
   logic qual_rise;
   logic timeout_hit;
   logic load_data;
   logic load_timeout;

   // An IN is ours only when the low address byte matches the served port.
   assign qual      = TRS_IN & (TRS_A == PORT);
   // qual_prev resets high so an IN already in progress at reset release
   // never looks like a fresh edge.
   assign qual_rise = qual & ~qual_prev;

`ifdef TRS_IN_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   assign timeout_hit = (state == WAIT_DATA) && (count == CW'(TIMEOUT_CYCLES - 1));

   // Cycles spent in WAIT_DATA; cleared on entry, saturates at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (state == IDLE && qual_rise) begin
         count <= '0;
      end else if (state == WAIT_DATA && count != '1) begin
         count <= count + CW'(1);
      end
   end

   // Sticky record that at least one read was released by timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_flag <= 1'b0;
      end else if (load_timeout) begin
         timeout_flag <= 1'b1;
      end
   end
`else
   logic timeout_unused;

   assign timeout_unused = (TIMEOUT_CYCLES != 0);
   assign timeout_hit    = 1'b0;
   assign timeout_flag   = 1'b0;
`endif

   // State register plus the previous-cycle qual used for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         qual_prev <= 1'b1;
      end else begin
         state     <= state_next;
         qual_prev <= qual;
      end
   end

   // Next-state logic; abort beats rdy, and rdy beats timeout.
   always_comb begin
      state_next   = state;
      load_data    = 1'b0;
      load_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (qual_rise) begin
               state_next = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (!TRS_IN) begin
               state_next = IDLE;
            end else if (le18_dout_rdy) begin
               load_data  = 1'b1;
               state_next = DRIVE;
            end else if (timeout_hit) begin
               load_timeout = 1'b1;
               state_next   = DRIVE;
            end
         end
         DRIVE: begin
            if (!TRS_IN) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // WAIT is combinational so the Z80 is held in the very cycle the IN is seen.
   always_comb begin
      TRS_WAIT = (state == WAIT_DATA) || ((state == IDLE) && qual_rise);
   end

   // Read-data latch and registered bus enable (high exactly while in DRIVE).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         TRS_DOUT    <= 8'h00;
         TRS_DOUT_EN <= 1'b0;
      end else begin
         if (load_data) begin
            TRS_DOUT <= le18_dout;
         end else if (load_timeout) begin
            TRS_DOUT <= 8'hFF;
         end
         TRS_DOUT_EN <= (state_next == DRIVE);
      end
   end

endmodule

// File: tb/tb_trs_in_responder.sv
// tb_trs_in_responder: directed and randomized stimulus for trs_in_responder,
// checked every cycle against a transaction-level reference model, with a few
// literal expectations from the worked examples.
module tb_trs_in_responder;

   localparam logic [7:0] PORT    = 8'hEC;
   localparam int         TIMEOUT = 64;

   // Reference-model phases of one IN transaction.
   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_BUS  = 2;
   localparam int PH_TURN = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] TRS_A = 8'h00;
   logic       TRS_IN = 1'b0;
   logic [7:0] le18_dout = 8'h00;
   logic       le18_dout_rdy = 1'b0;
   logic [7:0] TRS_DOUT;
   logic       TRS_DOUT_EN;
   logic       TRS_WAIT;
   logic       timeout_flag;

   int vectors = 0;
   int miscompares = 0;

   // Model state
   int         m_phase = PH_IDLE;
   logic       m_qual_prev = 1'b1;
   logic [7:0] m_dout = 8'h00;
   logic       m_flag = 1'b0;
   int         m_waited = 0;

   trs_in_responder #(.PORT(PORT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .TRS_A         (TRS_A),
      .TRS_IN        (TRS_IN),
      .le18_dout     (le18_dout),
      .le18_dout_rdy (le18_dout_rdy),
      .TRS_DOUT      (TRS_DOUT),
      .TRS_DOUT_EN   (TRS_DOUT_EN),
      .TRS_WAIT      (TRS_WAIT),
      .timeout_flag  (timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %02h, required %02h at %0t", name, act, req, $time);
      end
   endtask

   // Compare process: check outputs mid-cycle, then advance the model.
   always @(negedge clk) begin
      logic qual;
      logic rise;
      logic exp_wait;
      if (!reset) begin
         m_phase     = PH_IDLE;
         m_qual_prev = 1'b1;
         m_dout      = 8'h00;
         m_flag      = 1'b0;
         m_waited    = 0;
         check("rst_wait", {7'd0, TRS_WAIT}, 8'h00);
         check("rst_en", {7'd0, TRS_DOUT_EN}, 8'h00);
         check("rst_dout", TRS_DOUT, 8'h00);
         check("rst_flag", {7'd0, timeout_flag}, 8'h00);
      end else begin
         qual     = TRS_IN && (TRS_A == PORT);
         rise     = qual && !m_qual_prev;
         exp_wait = (m_phase == PH_WAIT) || (m_phase == PH_IDLE && rise);
         check("wait", {7'd0, TRS_WAIT}, {7'd0, exp_wait});
         check("dout_en", {7'd0, TRS_DOUT_EN}, {7'd0, m_phase == PH_BUS});
         check("dout", TRS_DOUT, m_dout);
         check("timeout_flag", {7'd0, timeout_flag}, {7'd0, m_flag});
         case (m_phase)
            PH_IDLE: if (rise) begin
               m_phase  = PH_WAIT;
               m_waited = 0;
            end
            PH_WAIT: begin
               m_waited++;
               if (!TRS_IN) begin
                  m_phase = PH_IDLE;
               end else if (le18_dout_rdy) begin
                  m_dout  = le18_dout;
                  m_phase = PH_BUS;
               end
`ifdef TRS_IN_TIMEOUT_EN
               else if (m_waited == TIMEOUT) begin
                  m_dout  = 8'hFF;
                  m_flag  = 1'b1;
                  m_phase = PH_BUS;
               end
`endif
            end
            PH_BUS:  if (!TRS_IN) m_phase = PH_TURN;
            default: m_phase = PH_IDLE;
         endcase
         m_qual_prev = qual;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plain read: raise IN, rdy after `delay` cycles, hold bus for a while.
   task automatic do_read(input logic [7:0] data, input int delay);
      TRS_A = PORT;
      TRS_IN = 1'b1;
      for (int i = 0; i < delay; i++) step();
      le18_dout = data;
      le18_dout_rdy = 1'b1;
      step();
      le18_dout_rdy = 1'b0;
      step();
   endtask

   initial begin
      // Reset with an IN already in progress; it must not start a transaction.
      TRS_A = PORT;
      TRS_IN = 1'b1;
      repeat (3) step();
      reset = 1'b1;
      repeat (4) step();
      check("held_in_no_wait", {7'd0, TRS_WAIT}, 8'h00);
      TRS_IN = 1'b0;
      repeat (2) step();

      // Worked example: rdy 3 cycles after IN, data 5A.
      TRS_A = 8'hEC;
      TRS_IN = 1'b1;
      #1 check("ex1_wait_c0", {7'd0, TRS_WAIT}, 8'h01);
      step();
      step();
      step();
      le18_dout = 8'h5A;
      le18_dout_rdy = 1'b1;
      #1 check("ex1_wait_c3", {7'd0, TRS_WAIT}, 8'h01);
      step();
      le18_dout_rdy = 1'b0;
      #1 check("ex1_wait_c4", {7'd0, TRS_WAIT}, 8'h00);
      check("ex1_en_c4", {7'd0, TRS_DOUT_EN}, 8'h01);
      check("ex1_dout_c4", TRS_DOUT, 8'h5A);
      repeat (3) step();
      TRS_IN = 1'b0;
      #1 check("ex1_en_c7", {7'd0, TRS_DOUT_EN}, 8'h01);
      step();
      #1 check("ex1_en_hold", {7'd0, TRS_DOUT_EN}, 8'h00);
      repeat (2) step();

      // Wrong port: never waits, never drives.
      TRS_A = 8'hED;
      TRS_IN = 1'b1;
      repeat (10) step();
      TRS_IN = 1'b0;
      repeat (2) step();

      // Abort on cycle 2 coinciding with rdy: data discarded.
      TRS_A = PORT;
      TRS_IN = 1'b1;
      step();
      step();
      TRS_IN = 1'b0;
      le18_dout = 8'hC3;
      le18_dout_rdy = 1'b1;
      step();
      le18_dout_rdy = 1'b0;
      #1 check("abort_en", {7'd0, TRS_DOUT_EN}, 8'h00);
      check("abort_dout", TRS_DOUT, 8'h5A);
      repeat (2) step();

`ifdef TRS_IN_TIMEOUT_EN
      // No rdy at all: forced release with FF.
      TRS_A = PORT;
      TRS_IN = 1'b1;
      repeat (TIMEOUT + 3) step();
      check("to_dout", TRS_DOUT, 8'hFF);
      check("to_flag", {7'd0, timeout_flag}, 8'h01);
      TRS_IN = 1'b0;
      repeat (3) step();
`endif

      // Stray rdy in IDLE, then a normal read of 81.
      le18_dout = 8'h33;
      le18_dout_rdy = 1'b1;
      step();
      le18_dout_rdy = 1'b0;
      step();
      do_read(8'h81, 2);
      check("stray_dout", TRS_DOUT, 8'h81);
      TRS_IN = 1'b0;
      repeat (3) step();

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) TRS_IN = ~TRS_IN;
         if ($urandom_range(0, 5) == 0)
            TRS_A = ($urandom_range(0, 2) == 0) ? 8'($urandom) : PORT;
         le18_dout     = 8'($urandom);
         le18_dout_rdy = ($urandom_range(0, 4) == 0);
         step();
      end
      TRS_IN = 1'b0;
      le18_dout_rdy = 1'b0;
      repeat (3) step();

      // Asynchronous reset while driving the bus.
      do_read(8'h9C, 1);
      #1 reset = 1'b0;
      #1 check("arst_en", {7'd0, TRS_DOUT_EN}, 8'h00);
      check("arst_wait", {7'd0, TRS_WAIT}, 8'h00);
      check("arst_dout", TRS_DOUT, 8'h00);
      repeat (2) step();
      reset = 1'b1;
      repeat (3) step();
      TRS_IN = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
